denise_colortable_wrctl: RTL and testbench

DENISE_COLORTABLE_WRCTL -- requirements
Module: denise_colortable_wrctl

---
 rtl/denise_colortable_wrctl.sv | 147 ++++++++++++++
 tb/tb_denise_colortable_wrctl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/denise_colortable_wrctl.sv
// Colour-table write controller: queues COLORxx register writes and retires them into the
// colour RAM only in slots the pixel pipeline leaves free, with read-modify-write for LOCT.
module denise_colortable_wrctl #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk7_en,
    input  logic [8:1]  reg_address_in,
    input  logic [15:0] data_in,
    input  logic [2:0]  bank,
    input  logic        loct,
    input  logic        pix_rd_req,
    input  logic [7:0]  pix_rdaddress,
    input  logic [31:0] ram_q,
    output logic        ram_enable,
    output logic        ram_wren,
    output logic [7:0]  ram_wraddress,
    output logic [7:0]  ram_rdaddress,
    output logic [31:0] ram_data,
    output logic [3:0]  ram_byteena,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [7:0]  addr;
        logic [11:0] rgb;
        logic        loct;
    } entry_t;

    typedef enum logic [1:0] {StIdle, StRd, StCap, StWr} state_e;

    entry_t          fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PtrW:0]   count_q;
    state_e          state_q;
    entry_t          work_q;
    logic [11:0]     merge_hi_q;
    logic            overflow_q;
    logic [7:0]      wraddr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      byteena_q;

    logic        capture;
    logic        free_slot;
    logic        full;
    logic        pop;
    logic        push;
    logic        wr_fire;
    logic [31:0] wr_data;
    entry_t      cap_entry;
    logic        unused_bits;

    assign cap_entry = {bank, reg_address_in[5:1], data_in[11:0], loct};
    assign capture   = clk7_en && (reg_address_in[8:6] == 3'b110);
    assign free_slot = clk7_en && !pix_rd_req;
    assign full      = (count_q == FullCount);
    assign pop       = clk7_en && (state_q == StIdle) && (count_q != '0);
    // A pop in the same cycle frees the slot the capture needs.
    assign push      = capture && (!full || pop);
    assign wr_fire   = (state_q == StWr) && free_slot;

    always_comb begin
        if (work_q.loct) begin
            wr_data = {8'h00, merge_hi_q[11:8], work_q.rgb[11:8], merge_hi_q[7:4],
                       work_q.rgb[7:4], merge_hi_q[3:0], work_q.rgb[3:0]};
        end else begin
            wr_data = {8'h00, {2{work_q.rgb[11:8]}}, {2{work_q.rgb[7:4]}},
                       {2{work_q.rgb[3:0]}}};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= cap_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            work_q     <= '0;
            merge_hi_q <= '0;
            overflow_q <= 1'b0;
            wraddr_q   <= '0;
            wdata_q    <= '0;
            byteena_q  <= '0;
        end else if (clk7_en) begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
            if (capture && !push) begin
                overflow_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        work_q  <= fifo_mem[rd_ptr_q];
                        state_q <= fifo_mem[rd_ptr_q].loct ? StRd : StWr;
                    end
                end
                StRd: begin
                    if (!pix_rd_req) begin
                        state_q <= StCap;
                    end
                end
                StCap: begin
                    // ram_q still carries the RD-slot result whatever the pixel side does now.
                    merge_hi_q <= {ram_q[23:20], ram_q[15:12], ram_q[7:4]};
                    state_q    <= StWr;
                end
                StWr: begin
                    if (!pix_rd_req) begin
                        wraddr_q  <= work_q.addr;
                        wdata_q   <= wr_data;
                        byteena_q <= 4'b0111;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ram_enable    = clk7_en;
    assign ram_wren      = wr_fire;
    assign ram_wraddress = wr_fire ? work_q.addr : wraddr_q;
    assign ram_data      = wr_fire ? wr_data : wdata_q;
    assign ram_byteena   = wr_fire ? 4'b0111 : byteena_q;
    assign ram_rdaddress = ((state_q == StRd) && free_slot) ? work_q.addr : pix_rdaddress;
    assign fifo_full     = full;
    assign overflow      = overflow_q;

    assign unused_bits = ^{data_in[15:12], ram_q[31:24], ram_q[19:16], ram_q[11:8], ram_q[3:0]};

endmodule

// File: tb/tb_denise_colortable_wrctl.sv
// Scoreboard bench for denise_colortable_wrctl: behavioural colour RAM, directed scenarios
// and randomized traffic checked against an in-order write model.
module tb_denise_colortable_wrctl;

    localparam int unsigned FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk7_en;
    logic [8:1]  reg_address_in;
    logic [15:0] data_in;
    logic [2:0]  bank;
    logic        loct;
    logic        pix_rd_req;
    logic [7:0]  pix_rdaddress;
    logic [31:0] ram_q;
    logic        ram_enable;
    logic        ram_wren;
    logic [7:0]  ram_wraddress;
    logic [7:0]  ram_rdaddress;
    logic [31:0] ram_data;
    logic [3:0]  ram_byteena;
    logic        fifo_full;
    logic        overflow;

    typedef struct {
        logic [7:0]  addr;
        logic [11:0] rgb;
        logic        loct;
        int          exp_cyc;
        logic        fixed;
        logic [31:0] fixed_data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   en_cnt = 0;

    denise_colortable_wrctl #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .clk7_en        (clk7_en),
        .reg_address_in (reg_address_in),
        .data_in        (data_in),
        .bank           (bank),
        .loct           (loct),
        .pix_rd_req     (pix_rd_req),
        .pix_rdaddress  (pix_rdaddress),
        .ram_q          (ram_q),
        .ram_enable     (ram_enable),
        .ram_wren       (ram_wren),
        .ram_wraddress  (ram_wraddress),
        .ram_rdaddress  (ram_rdaddress),
        .ram_data       (ram_data),
        .ram_byteena    (ram_byteena),
        .fifo_full      (fifo_full),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [7:0] a);
        if (a == 8'h05) return 32'h00A1B2C3;
        return {8'h00, a ^ 8'h3C, ~a, a + 8'h51};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Colour RAM: registered read, read-before-write, byte enables.
    initial begin : ram_model
        logic [31:0] mem [256];
        logic [31:0] rd;
        for (int i = 0; i < 256; i++) mem[i] = init_val(8'(i));
        ram_q <= '0;
        forever begin
            @(posedge clk);
            if (ram_enable) begin
                rd = mem[ram_rdaddress];
                if (ram_wren) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ram_byteena[b]) mem[ram_wraddress][b*8 +: 8] = ram_data[b*8 +: 8];
                    end
                end
                ram_q <= rd;
            end
        end
    end

    initial begin : monitor
        logic [31:0] ref_mem [256];
        logic [7:0]  last_wa;
        logic [31:0] last_d;
        logic [3:0]  last_be;
        logic [31:0] old;
        logic [31:0] exp_d;
        exp_t        e;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        last_wa = '0;
        last_d  = '0;
        last_be = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_q.delete();
                last_wa = '0;
                last_d  = '0;
                last_be = '0;
                check("rst_wren", 32'(ram_wren), 32'd0);
                check("rst_wraddress", 32'(ram_wraddress), 32'd0);
                check("rst_data", ram_data, 32'd0);
                check("rst_byteena", 32'(ram_byteena), 32'd0);
                check("rst_fifo_full", 32'(fifo_full), 32'd0);
                check("rst_overflow", 32'(overflow), 32'd0);
            end else begin
                check("ram_enable", 32'(ram_enable), 32'(clk7_en));
                if (!(clk7_en && !pix_rd_req)) begin
                    check("rdaddr_is_pixel", 32'(ram_rdaddress), 32'(pix_rdaddress));
                end
                if (ram_wren) begin
                    check("wren_in_free_slot", 32'(clk7_en && !pix_rd_req), 32'd1);
                    check("wr_byteena", 32'(ram_byteena), 32'h7);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr %h data %h, expected none",
                                 ram_wraddress, ram_data);
                    end else begin
                        e   = exp_q.pop_front();
                        old = ref_mem[e.addr];
                        if (e.fixed) begin
                            exp_d = e.fixed_data;
                        end else if (e.loct) begin
                            exp_d = {8'h00, old[23:20], e.rgb[11:8], old[15:12], e.rgb[7:4],
                                     old[7:4], e.rgb[3:0]};
                        end else begin
                            exp_d = {8'h00, {2{e.rgb[11:8]}}, {2{e.rgb[7:4]}}, {2{e.rgb[3:0]}}};
                        end
                        check("wr_addr", 32'(ram_wraddress), 32'(e.addr));
                        check("wr_data", ram_data, exp_d);
                        if (e.exp_cyc >= 0) check("wr_latency", 32'(en_cnt), 32'(e.exp_cyc));
                        ref_mem[e.addr] = exp_d;
                        last_wa = e.addr;
                        last_d  = exp_d;
                        last_be = 4'b0111;
                    end
                end else begin
                    check("hold_wraddress", 32'(ram_wraddress), 32'(last_wa));
                    check("hold_data", ram_data, last_d);
                    check("hold_byteena", 32'(ram_byteena), 32'(last_be));
                end
                if (clk7_en) en_cnt++;
            end
        end
    end

    // Disabled cycle: colour-register address on the bus must not be captured.
    task automatic junk();
        clk7_en        = 1'b0;
        pix_rd_req     = 1'($urandom);
        pix_rdaddress  = 8'($urandom);
        reg_address_in = {3'b110, 5'($urandom)};
        data_in        = 16'($urandom);
        bank           = 3'($urandom);
        loct           = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic en_idle(input logic pix, input int rd_exp);
        logic [8:1] ra;
        ra = 8'($urandom);
        if (ra[8:6] == 3'b110) ra[7] = 1'b0;
        clk7_en        = 1'b1;
        pix_rd_req     = pix;
        pix_rdaddress  = 8'($urandom);
        reg_address_in = ra;
        data_in        = 16'($urandom);
        bank           = 3'($urandom);
        loct           = 1'($urandom);
        if (rd_exp >= 0) begin
            #2;
            check("rmw_rdaddress", 32'(ram_rdaddress), 32'(rd_exp));
        end
        @(posedge clk);
        #1;
        junk();
    endtask

    task automatic en_write(input logic pix, input logic [8:1] ra, input logic [15:0] d,
                            input logic [2:0] bk, input logic lc, input int exp_off,
                            input logic fixed, input logic [31:0] fdata, input logic push);
        exp_t e;
        clk7_en        = 1'b1;
        pix_rd_req     = pix;
        pix_rdaddress  = 8'($urandom);
        reg_address_in = ra;
        data_in        = d;
        bank           = bk;
        loct           = lc;
        if (push) begin
            e.addr       = {bk, ra[5:1]};
            e.rgb        = d[11:0];
            e.loct       = lc;
            e.exp_cyc    = (exp_off < 0) ? -1 : en_cnt + exp_off;
            e.fixed      = fixed;
            e.fixed_data = fdata;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        junk();
    endtask

    function automatic logic [8:1] rand_color();
        return {3'b110, 5'($urandom)};
    endfunction

    logic       r_en;
    logic       r_pix;
    logic       r_wr;
    logic [8:1] r_ra;
    exp_t       r_e;

    initial begin
        reset_n        = 1'b0;
        clk7_en        = 1'b0;
        reg_address_in = '0;
        data_in        = '0;
        bank           = '0;
        loct           = 1'b0;
        pix_rd_req     = 1'b0;
        pix_rdaddress  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // First capture straight after reset; nibble duplication, 2-cycle latency.
        en_write(1'b0, 8'hC1, 16'h0F4A, 3'd2, 1'b0, 2, 1'b1, 32'h00FF44AA, 1'b1);
        repeat (4) en_idle(1'b0, -1);

        // LOCT read-modify-write; pixel read during CAP must not leak into the merge.
        en_write(1'b0, 8'hC5, 16'h0789, 3'd0, 1'b1, 4, 1'b1, 32'h00A7B8C9, 1'b1);
        en_idle(1'b1, -1);
        en_idle(1'b0, 8'h05);
        en_idle(1'b1, -1);
        en_idle(1'b0, -1);
        repeat (2) en_idle(1'b0, -1);

        // Pixel pipeline owns the RAM for 10 enabled cycles.
        en_write(1'b1, rand_color(), 16'($urandom), 3'($urandom), 1'b0, 10, 1'b0, '0, 1'b1);
        repeat (9) en_idle(1'b1, -1);
        repeat (3) en_idle(1'b0, -1);

        // Overflow: one entry parked in the engine, then FIFO_DEPTH+1 captures.
        en_write(1'b1, rand_color(), 16'($urandom), 3'($urandom), 1'b1, -1, 1'b0, '0, 1'b1);
        for (int k = 0; k <= int'(FIFO_DEPTH); k++) begin
            en_write(1'b1, rand_color(), 16'($urandom), 3'($urandom), 1'($urandom), -1, 1'b0,
                     '0, k < int'(FIFO_DEPTH));
            if (k == int'(FIFO_DEPTH) - 1) begin
                check("full_at_depth", 32'(fifo_full), 32'd1);
                check("no_overflow_yet", 32'(overflow), 32'd0);
            end
        end
        check("full_after_drop", 32'(fifo_full), 32'd1);
        check("overflow_set", 32'(overflow), 32'd1);
        repeat (4 * (FIFO_DEPTH + 1) + 4) en_idle(1'b0, -1);
        check("full_after_drain", 32'(fifo_full), 32'd0);
        check("overflow_sticky", 32'(overflow), 32'd1);
        check("overflow_drained", 32'(exp_q.size()), 32'd0);

        // Reset while the RMW is stuck in RD: the write is abandoned.
        en_write(1'b0, rand_color(), 16'($urandom), 3'($urandom), 1'b1, -1, 1'b0, '0, 1'b1);
        repeat (3) en_idle(1'b1, -1);
        reset_n        = 1'b0;
        clk7_en        = 1'b0;
        pix_rd_req     = 1'b0;
        pix_rdaddress  = '0;
        reg_address_in = '0;
        data_in        = '0;
        bank           = '0;
        loct           = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b1;
        repeat (6) en_idle(1'b0, -1);
        check("post_reset_full", 32'(fifo_full), 32'd0);
        check("post_reset_overflow", 32'(overflow), 32'd0);
        en_write(1'b0, rand_color(), 16'($urandom), 3'($urandom), 1'b0, 2, 1'b0, '0, 1'b1);
        repeat (3) en_idle(1'b0, -1);

        // Randomized traffic, kept within capacity so nothing is dropped.
        for (int i = 0; i < 800; i++) begin
            r_en  = ($urandom_range(0, 3) != 0);
            r_pix = 1'($urandom);
            r_wr  = r_en && ($urandom_range(0, 2) == 0) && (exp_q.size() < int'(FIFO_DEPTH));
            if (r_wr) begin
                r_ra = rand_color();
            end else begin
                r_ra = 8'($urandom);
                if (r_en && r_ra[8:6] == 3'b110) r_ra[8] = 1'b0;
            end
            clk7_en        = r_en;
            pix_rd_req     = r_pix;
            pix_rdaddress  = 8'($urandom);
            reg_address_in = r_ra;
            data_in        = 16'($urandom);
            bank           = 3'($urandom);
            loct           = 1'($urandom);
            if (r_wr) begin
                r_e.addr       = {bank, r_ra[5:1]};
                r_e.rgb        = data_in[11:0];
                r_e.loct       = loct;
                r_e.exp_cyc    = -1;
                r_e.fixed      = 1'b0;
                r_e.fixed_data = '0;
                exp_q.push_back(r_e);
            end
            @(posedge clk);
            #1;
        end
        repeat (60) en_idle(1'b0, -1);
        check("random_drained", 32'(exp_q.size()), 32'd0);
        check("random_no_overflow", 32'(overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
